// File: rtl/npu_mem_pkg.sv
// rtl/npu_mem_pkg.sv - shared types and helpers for the NPU scratch RAM
package npu_mem_pkg;

   localparam int LANE_W = 8;

   typedef enum logic [1:0] {
      RESET = 2'd0,
      CLEAR = 2'd1,
      READY = 2'd2
   } init_state_t;

   // One byte lane of a same-word write collision: port 1 wins where it is enabled.
   function automatic logic [LANE_W-1:0] be_merge(input logic [LANE_W-1:0] d1, input logic be1,
                                                  input logic [LANE_W-1:0] d2, input logic be2);
      if (be1)
         return d1;
      else if (be2)
         return d2;
      else
         return '0;
   endfunction

endpackage

// File: rtl/npu_dpram_core.sv
// rtl/npu_dpram_core.sv - two-write-port byte-enabled RAM array, old-data mixed-port reads
module npu_dpram_core #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4096,
   parameter int IDX_W  = 12
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   we_a,
   input  logic [DATA_W/8-1:0]    be_a,
   input  logic [IDX_W-1:0]       addr_a,
   input  logic [DATA_W-1:0]      wd_a,
   input  logic                   re_a,
   output logic [DATA_W-1:0]      q_a,
   input  logic                   we_b,
   input  logic [DATA_W/8-1:0]    be_b,
   input  logic [IDX_W-1:0]       addr_b,
   input  logic [DATA_W-1:0]      wd_b,
   input  logic                   re_b,
   output logic [DATA_W-1:0]      q_b
);
   localparam int BE_W = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < BE_W; i++) begin
         if (we_a && be_a[i])
            mem[addr_a][i*8 +: 8] <= wd_a[i*8 +: 8];
         if (we_b && be_b[i])
            mem[addr_b][i*8 +: 8] <= wd_b[i*8 +: 8];
      end
   end

   // Reads sample the array before this edge's writes land, giving old data across ports.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_a <= '0;
         q_b <= '0;
      end else begin
         if (re_a)
            q_a <= mem[addr_a];
         if (re_b)
            q_b <= mem[addr_b];
      end
   end

endmodule

// File: rtl/npu_dpram_avmm.sv
// rtl/npu_dpram_avmm.sv - dual Avalon-MM port scratch RAM with post-reset clear engine
module npu_dpram_avmm
   import npu_mem_pkg::*;
#(
   parameter int DATA_W         = 16,
   parameter int ADDR_W         = 12,
   parameter int DEPTH          = 4096,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ADDR_W-1:0]      address,
   input  logic [ADDR_W-1:0]      address2,
   input  logic [DATA_W/8-1:0]    byteenable,
   input  logic [DATA_W/8-1:0]    byteenable2,
   input  logic                   chipselect,
   input  logic                   chipselect2,
   input  logic                   read,
   input  logic                   read2,
   input  logic                   write,
   input  logic                   write2,
   input  logic [DATA_W-1:0]      writedata,
   input  logic [DATA_W-1:0]      writedata2,
   output logic [DATA_W-1:0]      readdata,
   output logic [DATA_W-1:0]      readdata2,
   output logic                   readdatavalid,
   output logic                   readdatavalid2,
   output logic                   waitrequest,
   output logic                   waitrequest2,
   output logic                   init_done
);
   localparam int                BE_W     = DATA_W / 8;
   localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

   init_state_t        state;
   logic [IDX_W-1:0]   clr_cnt;
   logic               wait_q;
   logic               init_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= RESET;
         clr_cnt <= '0;
         wait_q  <= 1'b1;
         init_q  <= 1'b0;
      end else begin
         case (state)
            RESET: begin
               clr_cnt <= '0;
               if (CLEAR_ON_RESET != 0) begin
                  state <= CLEAR;
               end else begin
                  state  <= READY;
                  wait_q <= 1'b0;
                  init_q <= 1'b1;
               end
            end
            CLEAR: begin
               if (clr_cnt == LAST_IDX) begin
                  state  <= READY;
                  wait_q <= 1'b0;
                  init_q <= 1'b1;
               end else begin
                  clr_cnt <= clr_cnt + IDX_W'(1);
               end
            end
            default: begin
               wait_q <= 1'b0;
               init_q <= 1'b1;
            end
         endcase
      end
   end

   assign waitrequest  = wait_q;
   assign waitrequest2 = wait_q;
   assign init_done    = init_q;

   logic acc1, acc2, wr1, wr2, rd1, rd2, inr1, inr2, wr1_ok, wr2_ok, collide, clearing;

   assign acc1     = chipselect & (read | write) & ~wait_q;
   assign acc2     = chipselect2 & (read2 | write2) & ~wait_q;
   assign wr1      = acc1 & write;
   assign wr2      = acc2 & write2;
   assign rd1      = acc1 & ~write;
   assign rd2      = acc2 & ~write2;
   assign inr1     = {1'b0, address} < DEPTH_X;
   assign inr2     = {1'b0, address2} < DEPTH_X;
   assign wr1_ok   = wr1 & inr1;
   assign wr2_ok   = wr2 & inr2;
   assign collide  = wr1_ok & wr2_ok & (address == address2);
   assign clearing = (state == CLEAR);

   logic [DATA_W-1:0] merged;

   always_comb begin
      merged = '0;
      for (int i = 0; i < BE_W; i++)
         merged[i*8 +: 8] = be_merge(writedata[i*8 +: 8], byteenable[i],
                                     writedata2[i*8 +: 8], byteenable2[i]);
   end

   // The clear engine borrows port A; hosts are stalled while it runs.
   logic               a_we;
   logic [BE_W-1:0]    a_be;
   logic [IDX_W-1:0]   a_addr;
   logic [DATA_W-1:0]  a_wd;
   logic [DATA_W-1:0]  q_a, q_b;

   assign a_we   = clearing | wr1_ok;
   assign a_be   = clearing ? '1 : (collide ? (byteenable | byteenable2) : byteenable);
   assign a_addr = clearing ? clr_cnt : address[IDX_W-1:0];
   assign a_wd   = clearing ? '0 : (collide ? merged : writedata);

   npu_dpram_core #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_core (
      .clk    (clk),
      .reset  (reset),
      .we_a   (a_we),
      .be_a   (a_be),
      .addr_a (a_addr),
      .wd_a   (a_wd),
      .re_a   (rd1),
      .q_a    (q_a),
      .we_b   (wr2_ok & ~collide),
      .be_b   (byteenable2),
      .addr_b (address2[IDX_W-1:0]),
      .wd_b   (writedata2),
      .re_b   (rd2),
      .q_b    (q_b)
   );

   logic               v1_q, v2_q, oor1_q, oor2_q;
   logic               s2_v1, s2_v2;
   logic [DATA_W-1:0]  s2_d1, s2_d2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         oor1_q <= 1'b0;
         oor2_q <= 1'b0;
         s2_v1  <= 1'b0;
         s2_v2  <= 1'b0;
         s2_d1  <= '0;
         s2_d2  <= '0;
      end else begin
         v1_q  <= rd1;
         v2_q  <= rd2;
         if (rd1)
            oor1_q <= ~inr1;
         if (rd2)
            oor2_q <= ~inr2;
         s2_v1 <= v1_q;
         s2_v2 <= v2_q;
         if (v1_q)
            s2_d1 <= oor1_q ? '0 : q_a;
         if (v2_q)
            s2_d2 <= oor2_q ? '0 : q_b;
      end
   end

   if (OUT_REG != 0) begin : g_oreg
      logic               o_v1, o_v2;
      logic [DATA_W-1:0]  o_d1, o_d2;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            o_v1 <= 1'b0;
            o_v2 <= 1'b0;
            o_d1 <= '0;
            o_d2 <= '0;
         end else begin
            o_v1 <= s2_v1;
            o_v2 <= s2_v2;
            if (s2_v1)
               o_d1 <= s2_d1;
            if (s2_v2)
               o_d2 <= s2_d2;
         end
      end

      assign readdata       = o_d1;
      assign readdata2      = o_d2;
      assign readdatavalid  = o_v1;
      assign readdatavalid2 = o_v2;
   end else begin : g_noreg
      assign readdata       = s2_d1;
      assign readdata2      = s2_d2;
      assign readdatavalid  = s2_v1;
      assign readdatavalid2 = s2_v2;
   end

endmodule

// File: tb/tb_npu_dpram_avmm.sv
// tb/tb_npu_dpram_avmm.sv - scoreboard bench for npu_dpram_avmm (two configurations, shared stimulus)
module tb_npu_dpram_avmm;

   logic        clk, reset;
   logic [4:0]  address, address2;
   logic [1:0]  byteenable, byteenable2;
   logic        chipselect, chipselect2, read, read2, write, write2;
   logic [15:0] writedata, writedata2;

   logic [15:0] rda, rda2, rdb, rdb2;
   logic        rva, rva2, rvb, rvb2, wra, wra2, wrb, wrb2, ida, idb;

   npu_dpram_avmm #(.DATA_W(16), .ADDR_W(5), .DEPTH(16), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut_a (
      .clk(clk), .reset(reset), .address(address), .address2(address2),
      .byteenable(byteenable), .byteenable2(byteenable2),
      .chipselect(chipselect), .chipselect2(chipselect2),
      .read(read), .read2(read2), .write(write), .write2(write2),
      .writedata(writedata), .writedata2(writedata2),
      .readdata(rda), .readdata2(rda2), .readdatavalid(rva), .readdatavalid2(rva2),
      .waitrequest(wra), .waitrequest2(wra2), .init_done(ida));

   npu_dpram_avmm #(.DATA_W(16), .ADDR_W(5), .DEPTH(10), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut_b (
      .clk(clk), .reset(reset), .address(address), .address2(address2),
      .byteenable(byteenable), .byteenable2(byteenable2),
      .chipselect(chipselect), .chipselect2(chipselect2),
      .read(read), .read2(read2), .write(write), .write2(write2),
      .writedata(writedata), .writedata2(writedata2),
      .readdata(rdb), .readdata2(rdb2), .readdatavalid(rvb), .readdatavalid2(rvb2),
      .waitrequest(wrb), .waitrequest2(wrb2), .init_done(idb));

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t        exp_q [4][$];
   logic [15:0] mem_m [2][32];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;

   function automatic int dep(input int d);
      return (d == 0) ? 16 : 10;
   endfunction

   function automatic int olat(input int d);
      return (d == 0) ? 0 : 1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic mon(input int k, input logic v, input logic [15:0] d);
      exp_t e;
      if (v) begin
         if (exp_q[k].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid port=%0d actual=%0h required=none (cycle %0d)", k, d, cyc);
         end else begin
            e = exp_q[k].pop_front();
            check($sformatf("rdata_p%0d", k), d, e.data);
            check($sformatf("latency_p%0d", k), cyc, e.cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, rva, rda);
      mon(1, rva2, rda2);
      mon(2, rvb, rdb);
      mon(3, rvb2, rdb2);
   end

   function automatic logic [15:0] model_rd(input int d, input int a);
      return (a < dep(d)) ? mem_m[d][a] : 16'h0000;
   endfunction

   task automatic model_wr(input int d, input int a, input logic [1:0] be, input logic [15:0] v);
      if (a < dep(d))
         for (int i = 0; i < 2; i++)
            if (be[i])
               mem_m[d][a][i*8 +: 8] = v[i*8 +: 8];
   endtask

   // Issue one cycle of requests at a negedge; reads see pre-cycle contents, port 1 overwrites port 2.
   task automatic drive(input logic c1, input logic r1, input logic w1, input int a1,
                        input logic [1:0] b1, input logic [15:0] d1,
                        input logic c2, input logic r2, input logic w2, input int a2,
                        input logic [1:0] b2, input logic [15:0] d2);
      exp_t e;
      chipselect  = c1; read  = r1; write  = w1; address  = 5'(a1); byteenable  = b1; writedata  = d1;
      chipselect2 = c2; read2 = r2; write2 = w2; address2 = 5'(a2); byteenable2 = b2; writedata2 = d2;
      for (int d = 0; d < 2; d++) begin
         if (c1 && r1 && !w1) begin
            e.data = model_rd(d, a1);
            e.cyc  = cyc + 2 + olat(d);
            exp_q[d*2].push_back(e);
         end
         if (c2 && r2 && !w2) begin
            e.data = model_rd(d, a2);
            e.cyc  = cyc + 2 + olat(d);
            exp_q[d*2+1].push_back(e);
         end
      end
      for (int d = 0; d < 2; d++) begin
         if (c2 && w2) model_wr(d, a2, b2, d2);
         if (c1 && w1) model_wr(d, a1, b1, d1);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(0, 0, 0, 0, 2'b00, 16'h0, 0, 0, 0, 0, 2'b00, 16'h0);
   endtask

   // Called at the negedge where reset was just released.
   task automatic measure_clear(input string tag);
      int cnt_a = 0;
      int cnt_b = 0;
      bit done_a = 0;
      bit done_b = 0;
      for (int i = 0; i < 100 && !(done_a && done_b); i++) begin
         @(negedge clk);
         if (!done_a) begin
            if (wra) cnt_a++;
            else begin
               done_a = 1;
               check({tag, "_init_a"}, ida, 1);
               check({tag, "_wait2_a"}, wra2, 0);
            end
         end
         if (!done_b) begin
            if (wrb) cnt_b++;
            else begin
               done_b = 1;
               check({tag, "_init_b"}, idb, 1);
               check({tag, "_wait2_b"}, wrb2, 0);
            end
         end
      end
      check({tag, "_clear_len_a"}, cnt_a, 16);
      check({tag, "_clear_len_b"}, cnt_b, 10);
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 32; a++)
            mem_m[d][a] = 16'h0000;
   endtask

   task automatic check_drained(input string tag);
      for (int k = 0; k < 4; k++)
         check($sformatf("%s_pending_p%0d", tag, k), exp_q[k].size(), 0);
   endtask

   initial begin
      reset = 1'b1;
      chipselect = 0; chipselect2 = 0; read = 0; read2 = 0; write = 0; write2 = 0;
      address = 0; address2 = 0; byteenable = 0; byteenable2 = 0; writedata = 0; writedata2 = 0;
      repeat (3) @(negedge clk);

      check("reset_outputs_a", {rda, rda2, rva, rva2, wra, wra2, ida}, {32'h0, 5'b00110});
      check("reset_outputs_b", {rdb, rdb2, rvb, rvb2, wrb, wrb2, idb}, {32'h0, 5'b00110});

      reset = 1'b0;
      measure_clear("clear");

      for (int a = 0; a < 16; a++)
         drive(1, 1, 0, a, 2'b00, 16'h0, 1, 1, 0, 15 - a, 2'b00, 16'h0);

      drive(1, 0, 1, 5, 2'b11, 16'h1234, 0, 0, 0, 0, 2'b00, 16'h0);
      drive(1, 0, 1, 5, 2'b01, 16'hABCD, 0, 0, 0, 0, 2'b00, 16'h0);
      drive(0, 0, 0, 0, 2'b00, 16'h0, 1, 1, 0, 5, 2'b00, 16'h0);

      drive(1, 0, 1, 7, 2'b10, 16'hAA00, 1, 0, 1, 7, 2'b11, 16'h00BB);
      drive(1, 1, 0, 7, 2'b00, 16'h0, 1, 1, 0, 7, 2'b00, 16'h0);

      drive(1, 0, 1, 3, 2'b11, 16'h1111, 0, 0, 0, 0, 2'b00, 16'h0);
      drive(1, 0, 1, 3, 2'b11, 16'h2222, 1, 1, 0, 3, 2'b00, 16'h0);
      drive(0, 0, 0, 0, 2'b00, 16'h0, 1, 1, 0, 3, 2'b00, 16'h0);

      drive(1, 0, 1, 12, 2'b11, 16'h5555, 0, 0, 0, 0, 2'b00, 16'h0);
      drive(1, 1, 0, 12, 2'b00, 16'h0, 1, 1, 0, 12, 2'b00, 16'h0);

      drive(1, 1, 1, 9, 2'b11, 16'h9999, 1, 1, 1, 2, 2'b10, 16'h7700);
      drive(1, 1, 0, 9, 2'b00, 16'h0, 1, 1, 0, 2, 2'b00, 16'h0);
      idle(4);

      for (int i = 0; i < 400; i++) begin
         int a1, a2;
         a1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
         a2 = ($urandom_range(0, 1) == 0) ? a1 : $urandom_range(0, 15);
         drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), a1, 2'($urandom), 16'($urandom),
               $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), a2, 2'($urandom), 16'($urandom));
      end
      idle(6);
      check_drained("random");

      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midclear_reset_a", {wra, ida, rva}, 3'b100);
      check("midclear_reset_b", {wrb, idb, rvb}, 3'b100);
      reset = 1'b0;
      measure_clear("restart");

      for (int a = 0; a < 16; a++)
         drive(1, 1, 0, a, 2'b00, 16'h0, 1, 1, 0, a, 2'b00, 16'h0);
      idle(6);
      check_drained("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
